// File: rtl/scroll_display.sv
// Scrolling ASCII message display: a writable character buffer viewed through a
// NUM_DIGITS-wide window on active-low seven-segment HEX digits.
module scroll_display #(
  parameter int NUM_DIGITS = 6,
  parameter int MSG_DEPTH  = 32,
  parameter int ADDR_W     = 5,
  parameter int TICK_DIV   = 25000000,
  parameter int DIV_W      = 25
) (
  input  logic                    CLOCK,
  input  logic                    RESETn,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [7:0]              wr_data,
  input  logic                    len_load,
  input  logic [ADDR_W:0]         len_in,
  input  logic                    run,
  input  logic                    dir,
  input  logic                    step,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [9:0]              LEDR
);

  localparam logic [DIV_W-1:0]  TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(MSG_DEPTH);
  localparam logic [6:0]        BLANK     = 7'h7F;

  logic [ADDR_W-1:0]       pos_q, pos_d;
  logic [ADDR_W:0]         len_q, len_d;
  logic [DIV_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              buf_q [MSG_DEPTH];
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    tick_s;
  logic [ADDR_W:0]         len_m1_s;
  logic [ADDR_W+1:0]       idx_s;

  // Case-insensitive ASCII to {g,f,e,d,c,b,a} active-low glyph.
  function automatic logic [6:0] decode_glyph(input logic [7:0] ch);
    case (ch)
      8'h41, 8'h61: decode_glyph = 7'b0001000;
      8'h42, 8'h62: decode_glyph = 7'b0000011;
      8'h43, 8'h63: decode_glyph = 7'b1000110;
      8'h44, 8'h64: decode_glyph = 7'b0100001;
      8'h45, 8'h65: decode_glyph = 7'b0000110;
      8'h46, 8'h66: decode_glyph = 7'b0001110;
      8'h47, 8'h67: decode_glyph = 7'b0010000;
      8'h48, 8'h68: decode_glyph = 7'b0001011;
      8'h30:        decode_glyph = 7'b1000000;
      8'h31:        decode_glyph = 7'b1111001;
      8'h32:        decode_glyph = 7'b0100100;
      8'h33:        decode_glyph = 7'b0110000;
      8'h34:        decode_glyph = 7'b0011001;
      8'h35:        decode_glyph = 7'b0010010;
      8'h36:        decode_glyph = 7'b0000010;
      8'h37:        decode_glyph = 7'b1111000;
      8'h38:        decode_glyph = 7'b0000000;
      8'h39:        decode_glyph = 7'b0010000;
      8'h2D:        decode_glyph = 7'b0111111;
      default:      decode_glyph = BLANK;
    endcase
  endfunction

  // Length, tick counter and scroll position next-state; len_load outranks tick/step.
  always_comb begin
    tick_s   = run && (cnt_q == TICK_LAST);
    len_m1_s = len_q - (ADDR_W+1)'(1);
    len_d    = len_q;
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    if (len_load) begin
      len_d = (len_in > DEPTH_L) ? DEPTH_L : len_in;
      cnt_d = '0;
      pos_d = '0;
    end else begin
      if (step || tick_s) begin
        cnt_d = '0;
      end else if (run) begin
        cnt_d = cnt_q + DIV_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      // A tick and a step together still make a single advance.
      if (step || tick_s) begin
        if (len_q == '0) begin
          pos_d = '0;
        end else if (!dir) begin
          pos_d = ({1'b0, pos_q} == len_m1_s) ? '0 : pos_q + ADDR_W'(1);
        end else begin
          pos_d = (pos_q == '0) ? len_m1_s[ADDR_W-1:0] : pos_q - ADDR_W'(1);
        end
      end else begin
        pos_d = pos_q;
      end
    end
  end

  // Window: leftmost digit (j=0) shows message index pos+j, wrapped once by len.
  always_comb begin
    hex_d = {(7*NUM_DIGITS){1'b1}};
    idx_s = '0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      idx_s = (ADDR_W+2)'(pos_q) + (ADDR_W+2)'(j);
      if (idx_s >= {1'b0, len_q}) begin
        idx_s = idx_s - {1'b0, len_q};
      end else begin
        idx_s = idx_s;
      end
      if ((ADDR_W+1)'(j) >= len_q) begin
        hex_d[7*(NUM_DIGITS-1-j) +: 7] = BLANK;
      end else begin
        hex_d[7*(NUM_DIGITS-1-j) +: 7] = decode_glyph(buf_q[idx_s[ADDR_W-1:0]]);
      end
    end
  end

  // Control state registers.
  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      pos_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      pos_q <= pos_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end

  // Message buffer, cleared to spaces on reset.
  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        buf_q[i] <= 8'h20;
      end
    end else if (wr_en) begin
      buf_q[wr_addr] <= wr_data;
    end
  end

  // Registered segment outputs, blank on reset.
  always_ff @(posedge CLOCK) begin
    if (!RESETn) begin
      hex_q <= {(7*NUM_DIGITS){1'b1}};
    end else begin
      hex_q <= hex_d;
    end
  end

  assign hex_out = hex_q;
  assign LEDR    = {{(10-ADDR_W){1'b0}}, pos_q};

endmodule
